// File: rtl/brick_map_if.sv
// Ball-collision hit handshake between the game engine and the brick map.
interface brick_map_if;
  logic       hit_valid;
  logic [2:0] hit_row;
  logic [2:0] hit_col;
  logic       hit_ready;
  logic       hit_ack;
  logic       hit_was_brick;

  modport master (
    output hit_valid, hit_row, hit_col,
    input  hit_ready, hit_ack, hit_was_brick
  );

  modport slave (
    input  hit_valid, hit_row, hit_col,
    output hit_ready, hit_ack, hit_was_brick
  );
endinterface

// File: rtl/brick_map_ctrl.sv
// Brick map controller: 8x8 brick storage, level load, hit clearing and win detection.
module brick_map_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        level_start,
  input  logic [7:0]  pattern,
  brick_map_if.slave  hit,
  input  logic [2:0]  rd_row,
  output logic [7:0]  bricks,
  output logic [6:0]  brick_count,
  output logic        busy,
  output logic        level_clear
);

  localparam int unsigned ROWS  = 8;
  localparam int unsigned COLS  = 8;
  localparam int unsigned CNT_W = 7;
  localparam int unsigned IDX_W = 3;

  typedef enum logic [2:0] {IDLE, LOAD, PLAY, CLEAR, WIN} state_e;

  state_e             state_q, state_d;
  logic [COLS-1:0]    mem_q [ROWS];
  logic [COLS-1:0]    mem_d [ROWS];
  logic [IDX_W-1:0]   row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [IDX_W-1:0]   hit_row_q, hit_row_d;
  logic [IDX_W-1:0]   hit_col_q, hit_col_d;
  logic               ack_q, ack_d;
  logic               was_q, was_d;
  logic [COLS-1:0]    bricks_q, bricks_d;
  logic               busy_q, busy_d;
  logic               clear_q, clear_d;

  // Hit acceptance is combinational so a new level start blocks it in the same cycle.
  assign hit.hit_ready     = (state_q == PLAY) && !level_start;
  assign hit.hit_ack       = ack_q;
  assign hit.hit_was_brick = was_q;
  assign bricks            = bricks_q;
  assign brick_count       = count_q;
  assign busy              = busy_q;
  assign level_clear       = clear_q;

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mem_q     <= '{default: '0};
      row_cnt_q <= '0;
      count_q   <= '0;
      hit_row_q <= '0;
      hit_col_q <= '0;
      ack_q     <= 1'b0;
      was_q     <= 1'b0;
      bricks_q  <= '0;
      busy_q    <= 1'b0;
      clear_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_q     <= mem_d;
      row_cnt_q <= row_cnt_d;
      count_q   <= count_d;
      hit_row_q <= hit_row_d;
      hit_col_q <= hit_col_d;
      ack_q     <= ack_d;
      was_q     <= was_d;
      bricks_q  <= bricks_d;
      busy_q    <= busy_d;
      clear_q   <= clear_d;
    end
  end

  // Next-state and output decode; level_start overrides everything else.
  always_comb begin
    state_d   = state_q;
    mem_d     = mem_q;
    row_cnt_d = row_cnt_q;
    count_d   = count_q;
    hit_row_d = hit_row_q;
    hit_col_d = hit_col_q;
    ack_d     = 1'b0;
    was_d     = was_q;
    bricks_d  = mem_q[rd_row];

    if (level_start) begin
      state_d   = LOAD;
      row_cnt_d = '0;
      count_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        LOAD: begin
          mem_d[row_cnt_q] = pattern;
          count_d          = count_q + CNT_W'($countones(pattern));
          row_cnt_d        = row_cnt_q + IDX_W'(1);
          if (row_cnt_q == IDX_W'(ROWS - 1)) begin
            state_d = (count_d == '0) ? WIN : PLAY;
          end
        end
        PLAY: begin
          if (hit.hit_valid) begin
            hit_row_d = hit.hit_row;
            hit_col_d = hit.hit_col;
            state_d   = CLEAR;
          end
        end
        CLEAR: begin
          ack_d = 1'b1;
          was_d = mem_q[hit_row_q][hit_col_q];
          if (mem_q[hit_row_q][hit_col_q]) begin
            mem_d[hit_row_q][hit_col_q] = 1'b0;
            count_d = count_q - CNT_W'(1);
          end
          state_d = (count_d == '0) ? WIN : PLAY;
        end
        WIN: ;
        default: state_d = IDLE;
      endcase
    end

    busy_d  = (state_d == LOAD);
    clear_d = (state_d == WIN);
  end

endmodule

// File: tb/tb_brick_map_ctrl.sv
// Randomized and directed checks of brick_map_ctrl against a row-array reference model.
module tb_brick_map_ctrl;

  localparam int M_IDLE  = 0;
  localparam int M_LOAD  = 1;
  localparam int M_PLAY  = 2;
  localparam int M_CLEAR = 3;
  localparam int M_WIN   = 4;

  logic       clk;
  logic       rst;
  logic       level_start;
  logic [7:0] pattern;
  logic [2:0] rd_row;
  logic [7:0] bricks;
  logic [6:0] brick_count;
  logic       busy;
  logic       level_clear;

  brick_map_if ifc ();

  brick_map_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .level_start (level_start),
    .pattern     (pattern),
    .hit         (ifc.slave),
    .rd_row      (rd_row),
    .bricks      (bricks),
    .brick_count (brick_count),
    .busy        (busy),
    .level_clear (level_clear)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the map as rows of bits plus the game phase.
  logic [7:0] m_rows [8];
  int         m_mode;
  int         m_loaded;
  int         m_pr, m_pc;
  logic       m_ack, m_was;
  logic [7:0] m_bricks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int bits_in_rows(input int upto);
    int s = 0;
    for (int r = 0; r < upto; r++) s += $countones(m_rows[r]);
    return s;
  endfunction

  function automatic int exp_count();
    return (m_mode == M_LOAD) ? bits_in_rows(m_loaded) : bits_in_rows(8);
  endfunction

  task automatic model_edge();
    if (rst) begin
      for (int r = 0; r < 8; r++) m_rows[r] = 8'h00;
      m_mode = M_IDLE; m_loaded = 0; m_ack = 1'b0; m_was = 1'b0; m_bricks = 8'h00;
      return;
    end
    m_bricks = m_rows[rd_row];
    m_ack    = 1'b0;
    if (level_start) begin
      m_mode = M_LOAD; m_loaded = 0;
    end else if (m_mode == M_LOAD) begin
      m_rows[m_loaded] = pattern;
      m_loaded++;
      if (m_loaded == 8) m_mode = (bits_in_rows(8) == 0) ? M_WIN : M_PLAY;
    end else if (m_mode == M_PLAY) begin
      if (ifc.hit_valid) begin
        m_pr = int'(ifc.hit_row); m_pc = int'(ifc.hit_col); m_mode = M_CLEAR;
      end
    end else if (m_mode == M_CLEAR) begin
      m_ack = 1'b1;
      m_was = m_rows[m_pr][m_pc];
      m_rows[m_pr][m_pc] = 1'b0;
      m_mode = (bits_in_rows(8) == 0) ? M_WIN : M_PLAY;
    end
  endtask

  // One clock: check the combinational ready, advance, then compare registered outputs.
  task automatic step();
    #1;
    chk("hit_ready", 32'(ifc.hit_ready), 32'(m_mode == M_PLAY && !level_start));
    @(posedge clk);
    model_edge();
    #1;
    chk("brick_count", 32'(brick_count), 32'(exp_count()));
    chk("busy", 32'(busy), 32'(m_mode == M_LOAD));
    chk("level_clear", 32'(level_clear), 32'(m_mode == M_WIN));
    chk("hit_ack", 32'(ifc.hit_ack), 32'(m_ack));
    chk("hit_was_brick", 32'(ifc.hit_was_brick), 32'(m_was));
    chk("bricks", 32'(bricks), 32'(m_bricks));
  endtask

  task automatic do_load(input logic [7:0] pat);
    pattern = pat; level_start = 1'b1; step();
    level_start = 1'b0;
    for (int i = 0; i < 8; i++) step();
  endtask

  task automatic do_hit(input int r, input int c);
    ifc.hit_valid = 1'b1; ifc.hit_row = 3'(r); ifc.hit_col = 3'(c); step();
    ifc.hit_valid = 1'b0; step();
  endtask

  initial begin
    rst = 1'b1; level_start = 1'b0; pattern = 8'h00; rd_row = 3'd0;
    ifc.hit_valid = 1'b0; ifc.hit_row = 3'd0; ifc.hit_col = 3'd0;
    for (int r = 0; r < 8; r++) m_rows[r] = 8'hA5;
    m_mode = M_IDLE; m_loaded = 0; m_pr = 0; m_pc = 0;
    m_ack = 1'b0; m_was = 1'b0; m_bricks = 8'h00;
    step(); step();
    chk("reset_count", 32'(brick_count), 32'd0);
    rst = 1'b0;

    // Hits are ignored while idle.
    ifc.hit_valid = 1'b1; step(); step(); ifc.hit_valid = 1'b0;

    // Full load, then every row reads all ones.
    do_load(8'hFF);
    chk("full_count", 32'(brick_count), 32'd64);
    chk("full_ready", 32'(ifc.hit_ready), 32'd1);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r); step();
      chk("full_row", 32'(bricks), 32'hFF);
    end

    // Hit a brick, then the same empty cell.
    do_hit(2, 5);
    chk("hit1_ack", 32'(ifc.hit_ack), 32'd1);
    chk("hit1_was", 32'(ifc.hit_was_brick), 32'd1);
    chk("hit1_count", 32'(brick_count), 32'd63);
    rd_row = 3'd2; step();
    chk("hit1_row", 32'(bricks), 32'hDF);
    do_hit(2, 5);
    chk("hit2_ack", 32'(ifc.hit_ack), 32'd1);
    chk("hit2_was", 32'(ifc.hit_was_brick), 32'd0);
    chk("hit2_count", 32'(brick_count), 32'd63);

    // Single column cleared row by row reaches the win state.
    do_load(8'h01);
    for (int r = 0; r < 8; r++) do_hit(r, 0);
    chk("win_count", 32'(brick_count), 32'd0);
    chk("win_clear", 32'(level_clear), 32'd1);
    #1 chk("win_ready", 32'(ifc.hit_ready), 32'd0);
    do_load(8'h00);
    chk("empty_win", 32'(level_clear), 32'd1);

    // Restart in the middle of a load while a hit is offered.
    pattern = 8'h5A; level_start = 1'b1; step(); level_start = 1'b0;
    for (int i = 0; i < 4; i++) step();
    level_start = 1'b1; ifc.hit_valid = 1'b1; step();
    level_start = 1'b0; ifc.hit_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk("restart_busy", 32'(busy), 32'd1);
      step();
    end
    chk("restart_count", 32'(brick_count), 32'd32);

    // Reset during a clear cycle suppresses the ack.
    ifc.hit_valid = 1'b1; ifc.hit_row = 3'd0; ifc.hit_col = 3'd1; step();
    ifc.hit_valid = 1'b0; rst = 1'b1; step(); rst = 1'b0;
    chk("rst_ack", 32'(ifc.hit_ack), 32'd0);
    chk("rst_count", 32'(brick_count), 32'd0);
    for (int r = 0; r < 8; r++) begin
      rd_row = 3'(r); step();
      chk("rst_row", 32'(bricks), 32'h00);
    end

    // Random play with occasional restarts and resets.
    for (int i = 0; i < 4000; i++) begin
      rst         = ($urandom_range(0, 299) == 0);
      level_start = ($urandom_range(0, 39) == 0);
      pattern     = 8'($urandom & $urandom & $urandom);
      ifc.hit_valid = ($urandom_range(0, 1) == 1);
      ifc.hit_row   = 3'($urandom_range(0, 7));
      ifc.hit_col   = 3'($urandom_range(0, 7));
      rd_row        = 3'($urandom_range(0, 7));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
